// File: rtl/affine_addr_gen_pkg.sv
// Shared types and helpers for the N-D affine address generator.
// Holds the FSM state type and extent normalisation.
package affine_addr_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_DIMS = 8;
  localparam int MAX_CW   = 32;

  // An extent of 0 behaves as a single-iteration dimension.
  function automatic logic [MAX_CW-1:0] eff_max(
    input logic [MAX_CW-1:0] m
  );
    return (m == '0) ? MAX_CW'(1) : m;
  endfunction

endpackage

// File: rtl/affine_addr_gen_nd_dim.sv
// One loop dimension: index counter plus running partial sum.
// Chained by carry; exposes the post-update partial sum.
module affine_dim_counter
  import affine_addr_gen_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step_en_i,
  input  logic          carry_in_i,
  input  logic          clear_i,
  input  logic [CW-1:0] max_i,
  input  logic [AW-1:0] stride_i,
  output logic [AW-1:0] part_o,
  output logic          at_max_o,
  output logic          carry_out_o
);

  logic [CW-1:0] emax;
  logic [CW-1:0] idx_q, idx_d;
  logic [AW-1:0] part_q, part_d;
  logic          wrap;

  assign emax        = CW'(eff_max(MAX_CW'(max_i)));
  assign wrap        = (idx_q == emax - CW'(1));
  assign carry_out_o = carry_in_i && wrap;

  // Next index/partial sum: clear, wrap to zero, or step by stride.
  always_comb begin
    idx_d  = idx_q;
    part_d = part_q;
    if (clear_i) begin
      idx_d  = '0;
      part_d = '0;
    end else if (step_en_i && carry_in_i) begin
      if (wrap) begin
        idx_d  = '0;
        part_d = '0;
      end else begin
        idx_d  = idx_q + CW'(1);
        part_d = part_q + stride_i;
      end
    end
  end

  assign part_o   = part_d;
  assign at_max_o = (idx_d == emax - CW'(1));

  // Counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      part_q <= '0;
    end else begin
      idx_q  <= idx_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/affine_addr_gen_nd.sv
// N-D affine address generator: config handshake, FSM,
// offset+partial-sum adder and registered valid/ready output.
module affine_addr_gen_nd
  import affine_addr_gen_pkg::*;
#(
  parameter int DIMS = 3,
  parameter int AW   = 32,
  parameter int CW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [AW-1:0]      cfg_offset,
  input  logic [DIMS*CW-1:0] cfg_max,
  input  logic [DIMS*AW-1:0] cfg_stride,
  input  logic               abort,
  output logic               addr_valid,
  input  logic               addr_ready,
  output logic [AW-1:0]      addr,
  output logic               addr_last,
  output logic               busy
);

  state_e             state_q;
  logic               valid_q;
  logic               last_q;
  logic [AW-1:0]      addr_q;
  logic [AW-1:0]      offset_q;
  logic [DIMS*CW-1:0] max_q;
  logic [DIMS*AW-1:0] stride_q;

  logic               cfg_fire;
  logic               accept;
  logic               step;
  logic               first_last;
  logic [DIMS:0]      carry;
  logic [DIMS-1:0]    at_max;
  logic [AW-1:0]      part [DIMS];
  logic [AW-1:0]      sum;

  assign cfg_fire = cfg_valid && (state_q == IDLE);
  assign accept   = valid_q && addr_ready;
  assign step     = accept && !abort && (state_q == RUN);
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIMS; g++) begin : g_dim
    affine_dim_counter #(
      .AW(AW),
      .CW(CW)
    ) u_dim (
      .clk         (clk),
      .rst_n       (rst_n),
      .step_en_i   (step),
      .carry_in_i  (carry[g]),
      .clear_i     (cfg_fire),
      .max_i       (max_q[g*CW +: CW]),
      .stride_i    (stride_q[g*AW +: AW]),
      .part_o      (part[g]),
      .at_max_o    (at_max[g]),
      .carry_out_o (carry[g+1])
    );
  end

  // Next address: base plus the post-update partial sums.
  always_comb begin
    sum = offset_q;
    for (int d = 0; d < DIMS; d++) begin
      sum = sum + part[d];
    end
  end

  // First address is also last when every extent is 0 or 1.
  always_comb begin
    first_last = 1'b1;
    for (int d = 0; d < DIMS; d++) begin
      if (cfg_max[d*CW +: CW] > CW'(1)) first_last = 1'b0;
    end
  end

  // FSM with config latch and registered address outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      offset_q <= '0;
      max_q    <= '0;
      stride_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_fire) begin
            offset_q <= cfg_offset;
            max_q    <= cfg_max;
            stride_q <= cfg_stride;
            addr_q   <= cfg_offset;
            last_q   <= first_last;
            valid_q  <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= IDLE;
          end else if (accept) begin
            if (carry[DIMS]) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              addr_q <= sum;
              last_q <= &at_max;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign addr_last  = last_q;

endmodule

// File: doc/affine_addr_gen_nd.md
Name: affine_addr_gen_nd

Overview:
- Parametrised N-dimensional affine address generator.
- Emits addr = offset + sum over d of (idx[d] * stride[d]), with idx[0] fastest-varying and each idx[d] wrapping at max[d].
- Successor to the fixed 2-D free-running scan generator: adds a configurable dimension count, a config handshake, output valid/ready backpressure, a last flag, abort, and a multiplier-free incremental datapath.
- Sits between the controller that loads access patterns and the memory port that consumes addresses.

Parameters:
- DIMS, 3, number of loop dimensions (1..8).
- AW, 32, address and stride width.
- CW, 16, per-dimension extent width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config offered.
- cfg_ready  out  1  block can accept a config (high only in IDLE).
- cfg_offset  in  AW  base address.
- cfg_max  in  DIMS*CW  per-dimension extent; dim d occupies bits [d*CW +: CW].
- cfg_stride  in  DIMS*AW  per-dimension stride; dim d occupies bits [d*AW +: AW].
- abort  in  1  synchronous cancel of the current pattern.
- addr_valid  out  1  addr is valid.
- addr_ready  in  1  consumer accepts addr.
- addr  out  AW  generated address.
- addr_last  out  1  marks the final address of the pattern.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cfg_ready=1, addr_valid=0, addr=0, addr_last=0, busy=0. All counters, partial sums and config registers clear to 0.
- States: IDLE, RUN.
- IDLE -> RUN on cfg_valid && cfg_ready.
  - Config fields are latched on that edge.
  - idx[d]=0 and part[d]=0 for every d.
  - Next cycle: addr_valid=1, addr=cfg_offset, busy=1, cfg_ready=0.
  - Latency from config handshake to first valid address: 1 cycle.
- Extent rules: a latched max of 0 is treated as 1. Total address count is the product of the effective max[d].
- Advance occurs on an accept, i.e. addr_valid && addr_ready.
  - idx[0] increments. If idx[0]==max[0]-1 it wraps to 0 and carries into dim 1; the carry ripples upward the same way.
  - On each increment of dim d: part[d] += stride[d].
  - On each wrap of dim d: part[d] = 0.
  - Next addr = offset + sum of the updated part[d], registered. Throughput is 1 address per cycle under continuous ready.
- Arithmetic: all sums are modulo 2^AW; overflow wraps silently. Strides are unsigned, so a negative step is expressed as a two's-complement stride.
- Backpressure: while addr_valid && !addr_ready, addr and addr_last hold stable and no counter moves.
- addr_last=1 exactly when idx[d]==max[d]-1 for all d. It is registered alongside addr.
- Completion: an accept with addr_last=1 moves to IDLE. Next cycle: addr_valid=0, cfg_ready=1, busy=0. A new config can be accepted that cycle, giving a gap of at least 1 cycle between patterns.
- Abort: abort=1 in RUN forces IDLE next cycle with addr_valid=0.
  - Abort takes priority over a simultaneous accept; that accept is still considered consumed by the consumer.
  - Abort in IDLE is ignored.
- cfg_valid while in RUN is ignored; cfg_ready stays 0.
- Reset asserted mid-pattern returns to reset values immediately. No address is emitted after rst_n deasserts until a new config is accepted.

Decomposition:
- Package affine_addr_gen_pkg:
  - state_e enum {IDLE, RUN}.
  - MAX_DIMS=8 constant.
  - Function eff_max(cw-bit) that maps 0 to 1.
- Sub-module affine_dim_counter, instantiated DIMS times and chained by carry.
  - Inputs: step_en, carry_in, max, stride, clear.
  - Outputs: idx, part, at_max, carry_out.
- Top level holds the FSM, the offset+part adder tree, and the output register.

Test Plan:
- DIMS=2, max={3,2}, stride={4,100}, offset=0x1000, ready held high -> addr 0x1000,0x1004,0x1008,0x1064,0x1068,0x106C; last on the 6th only; busy drops the cycle after.
- Same config with ready toggled 1,0,0,1,... -> addr and last held during stalls; sequence identical, no duplicates or skips.
- max={0,1,5}, stride={7,9,0xFFFFFFFC}, offset=20 -> 20,16,12,8,4; dims 0 and 1 are degenerate.
- offset=0xFFFFFFF8, max={4,1,1}, stride={4,..} -> 0xFFFFFFF8,0xFFFFFFFC,0x0,0x4 (modular wrap).
- abort asserted on the 3rd accept of a 6-address pattern -> addr_valid=0 next cycle, cfg_ready=1; a new config then starts cleanly at its own offset.
- rst_n pulsed low mid-pattern -> outputs at reset values asynchronously; after release, no addr_valid until cfg_valid; cfg_valid asserted during RUN is ignored.
